// File: rtl/uart_tx_engine_if.sv
// Write-side push port of uart_tx_engine: valid/ready handshake carrying one data word.
interface uart_tx_engine_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmitter with TX FIFO, programmable divisor, width, parity and stop bits.
// Optional CTS flow control compiled in with `define UART_TX_CTS_FLOW_EN.
module uart_tx_engine #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DIV_W  = 16
) (
  input  logic                     pclk,
  input  logic                     prst,
  input  logic                     en,
  input  logic [DIV_W-1:0]         div,
  input  logic [1:0]               par_mode,
  input  logic                     stop2,
  uart_tx_engine_if.slave          wr,
  input  logic                     uart_cts,
  output logic                     uart_tx,
  output logic                     tx_busy,
  output logic [$clog2(DEPTH):0]   tx_level,
  output logic                     tx_done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned BW = $clog2(DATA_W);
  localparam logic [LW-1:0] LvlFull = LW'(DEPTH);
  localparam logic [BW-1:0] BitLast = BW'(DATA_W - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q;

  logic [2:0]        state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              stop_q, stop_d;
  logic              stop2_q, stop2_d;
  logic              par_on_q, par_on_d;
  logic              par_bit_q, par_bit_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;

  logic push, pop, start_ok, bit_end, cts_ok;
  logic [DATA_W-1:0] head;

`ifdef UART_TX_CTS_FLOW_EN
  assign cts_ok = uart_cts;
`else
  logic unused_cts;
  assign unused_cts = uart_cts;
  assign cts_ok     = 1'b1;
`endif

  assign wr.wr_ready = (level_q != LvlFull);
  assign push        = wr.wr_valid & wr.wr_ready;
  assign head        = mem_q[rd_ptr_q];
  assign start_ok    = en & (level_q != '0) & cts_ok;
  assign bit_end     = (cnt_q == div_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    div_d     = div_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    stop_d    = stop_q;
    stop2_d   = stop2_q;
    par_on_d  = par_on_q;
    par_bit_d = par_bit_q;
    done_d    = 1'b0;
    pop       = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        pop   = start_ok;
      end
      StStart: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == BitLast) begin
            stop_d  = 1'b0;
            state_d = par_on_q ? StParity : StStop;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          cnt_d   = '0;
          stop_d  = 1'b0;
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_end) begin
          cnt_d = '0;
          if (stop2_q && !stop_q) begin
            stop_d = 1'b1;
          end else begin
            done_d  = 1'b1;
            pop     = start_ok;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Frame start: pop the head and freeze the frame's configuration.
    if (pop) begin
      state_d   = StStart;
      cnt_d     = '0;
      shift_d   = head;
      div_d     = div;
      stop2_d   = stop2;
      par_on_d  = (par_mode == 2'b01) || (par_mode == 2'b10);
      par_bit_d = (^head) ^ (par_mode == 2'b10);
    end

    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = par_bit_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (push) mem_q[wr_ptr_q] <= wr.wr_data;
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      state_q   <= StIdle;
      cnt_q     <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      stop_q    <= 1'b0;
      stop2_q   <= 1'b0;
      par_on_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !push) level_q <= level_q - 1'b1;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      stop_q    <= stop_d;
      stop2_q   <= stop2_d;
      par_on_q  <= par_on_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  assign uart_tx  = tx_q;
  assign tx_busy  = (state_q != StIdle);
  assign tx_level = level_q;
  assign tx_done  = done_q;

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Parametrised successor to the fixed 8-bit UART transmit path: a self-contained transmitter with an integrated TX FIFO, programmable baud divider, data width, parity mode and stop-bit count. Sits between a register-interface block, which pushes bytes through a valid/ready port and supplies configuration, and the `uart_tx` pad. Optional CTS flow control is compiled in by macro.

## Interface
Parameters:
- `DATA_W`, 8: data bits per frame; legal range 5..9.
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `DIV_W`, 16: width of the baud divisor.

Ports:
- `pclk` in 1: clock; the block has one clock.
- `prst` in 1: reset, synchronous and active-high.
- `en` in 1: transmitter enable; gates only the start of new frames.
- `div` in DIV_W: each bit lasts `div+1` pclk cycles.
- `par_mode` in 2: 00 none, 01 even, 10 odd, 11 treated as none.
- `stop2` in 1: 0 gives one stop bit; 1 gives two.
- `wr_valid` in 1: push request.
- `wr_data` in DATA_W: push data.
- `wr_ready` out 1: high when the FIFO is not full.
- `uart_cts` in 1: clear-to-send, active-high; used only with the macro enabled.
- `uart_tx` out 1: serial output, idle high.
- `tx_busy` out 1: high when the FSM is not in IDLE.
- `tx_level` out $clog2(DEPTH)+1: FIFO occupancy.
- `tx_done` out 1: one-cycle pulse at the end of each frame.

## Operation
- **FIFO writes.** A write occurs when `wr_valid & wr_ready`. `wr_ready = (tx_level != DEPTH)`, derived from the registered level with no same-cycle pop bypass.
- **FSM states.** IDLE, START, DATA, PARITY, STOP.
- **IDLE to START.** The FSM leaves IDLE when all of the following hold:
  - `en` = 1
  - FIFO non-empty
  - CTS permits (see Configuration)
- **Frame start actions.** On entering START, the FSM pops the FIFO head into the shift register. It also latches `div`, `par_mode`, `stop2` and the shift data; these are held for the whole frame.
- **Output per state.**
  - START: drives 0.
  - DATA: drives `DATA_W` bits, LSB first.
  - PARITY: present only if `par_mode` is 01 or 10. Even mode drives the XOR of the data bits. Odd mode drives its inverse.
  - STOP: drives 1 for 1 or 2 bit periods.
- **Bit timing.**
  - The bit counter reloads to 0 on each state entry and on each bit boundary.
  - A bit ends when the counter equals the latched div.
- **End of STOP.**
  - `tx_done` pulses for one cycle.
  - The FSM goes to START directly if the start conditions hold, otherwise to IDLE. Back-to-back frames therefore have no idle gap.
- **Frame length.** `(1 + DATA_W + P + S) * (div+1)` cycles, where P is 0 or 1 and S is 1 or 2.
- **`en` deasserted mid-frame.** The current frame completes, then the FSM stays in IDLE. Writes are still accepted.
- **`div` changed mid-frame.** No effect until the next frame.
- **Simultaneous push and pop.** Level is unchanged and the data order is preserved.
- **Overflow.** Writes while full are impossible because `wr_ready` = 0.
- **Reset mid-frame.**
  - FIFO emptied and FSM to IDLE.
  - `uart_tx` = 1 from the next cycle.
  - No `tx_done` pulse.

## Timing
- **Reset values.**
  - `uart_tx` = 1.
  - `wr_ready` = 1.
  - `tx_busy` = 0, `tx_done` = 0.
  - `tx_level` = 0.
- **Write-to-start latency.** For a push at edge k into an empty FIFO with IDLE and all conditions true:
  - `tx_level` = 1 after edge k.
  - START is entered at edge k+1, and `uart_tx` falls after edge k+1.
  - `tx_level` returns to 0 after edge k+1.
- **Registered outputs.** `tx_busy` and `uart_tx` change on the same edge as the state.
- **`tx_done` timing.** Asserted in the cycle after the final stop-bit cycle.
- **Minimum bit period.** `div` = 0 gives 1 cycle per bit.

## Configuration
- **Macro.** `UART_TX_CTS_FLOW_EN`.
- **Defined.** `uart_cts` is sampled only at frame-start decisions (IDLE and end of STOP).
  - `uart_cts` = 0 blocks new frames.
  - Deassertion mid-frame never truncates the frame in flight.
- **Undefined.** The `uart_cts` port still exists but is ignored; frames start regardless.

## Test plan
- **Basic frame.** DATA_W=8, div=3, par_mode=00, stop2=0; push 0xA5.
  - `uart_tx` is 0 for 4 cycles.
  - Then bits 1,0,1,0,0,1,0,1 at 4 cycles each.
  - Then 1 for 4 cycles.
  - `tx_done` pulses 40 cycles after START entry.
- **Parity and two stop bits.** Push 0x03 with even parity: parity bit is 0. Push 0x03 with odd parity: parity bit is 1. With stop2=1, the frame is 12*(div+1) cycles.
- **FIFO full.** DEPTH=16, en=0, 17 consecutive valid pushes.
  - The first 16 are accepted and `tx_level` = 16.
  - The 17th is held with `wr_ready` = 0.
  - Set en=1: 16 back-to-back frames in push order with no idle gaps.
- **CTS flow control (macro defined).**
  - cts=0 then push 0x55: `uart_tx` stays high.
  - Raise cts: START follows at the next edge.
  - Drop cts mid-frame: that frame completes and the next queued frame waits.
- **Reset mid-frame.** Assert `prst` during DATA with 3 entries queued.
  - Next cycle: `uart_tx` = 1, `tx_level` = 0, `tx_busy` = 0.
  - No `tx_done` pulse.
- **Enable and divisor mid-frame.** Drop `en` and change `div` 3→7 mid-frame.
  - The current frame keeps 4-cycle bits and completes.
  - No new START occurs until en=1, after which bits are 8 cycles.
